// File: rtl/sseg_scan_pkg.sv
// sseg_scan_pkg: shared constants and types for the seven-segment scanner
package sseg_scan_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] BLANK_NUM = 4'hF;
  typedef logic [$clog2(NUM_DIGITS)-1:0] dig_t;
  function automatic logic [3:0] anode(input dig_t d);
    return ~(4'b0001 << d);
  endfunction
endpackage

// File: rtl/sseg_scan_if.sv
// sseg_scan_if: host-side value/control inputs and display-side outputs of the scanner
interface sseg_scan_if;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic        lzb;
  logic [3:0]  num;
  logic [3:0]  an;
  logic        dp_n;
  logic        frame_done;
  modport master(output value, load, dp_in, lzb, input num, an, dp_n, frame_done);
  modport slave(input value, load, dp_in, lzb, output num, an, dp_n, frame_done);
endinterface

// File: rtl/sseg_tick.sv
// sseg_tick: free-running prescaler, tick high in the last cycle of each CLK_DIV period
module sseg_tick #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(CLK_DIV - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/sseg_scan.sv
// sseg_scan: four-digit multiplexed display scanner with tear-free frame updates
// and leading-zero blanking; num feeds an external sseg_driver.
module sseg_scan
  import sseg_scan_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input logic       clk,
  input logic       reset,
  sseg_scan_if.slave bus
);
  logic        tick, wrap, blank, pflag, dp_q, fd_q;
  dig_t        dig;
  logic [15:0] shadow, pend;
  logic [3:0]  an_q, num_q;
  sseg_tick #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .reset(reset), .tick(tick));
  assign wrap = tick && dig == dig_t'(NUM_DIGITS - 1);
  // a digit is blank when it and every more-significant nibble are zero
  assign blank = bus.lzb && dig != '0 && (shadow >> {dig, 2'b00}) == '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dig    <= '0;
      shadow <= '0;
      pend   <= '0;
      pflag  <= 1'b0;
    end else begin
      if (tick) dig <= dig + dig_t'(1);
      if (bus.load) pend <= bus.value;
      if (wrap) begin
        shadow <= bus.load ? bus.value : pflag ? pend : shadow;
        pflag  <= 1'b0;
      end else if (bus.load) pflag <= 1'b1;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      an_q  <= AN_OFF;
      num_q <= '0;
      dp_q  <= 1'b1;
      fd_q  <= 1'b0;
    end else begin
      an_q  <= blank ? AN_OFF : anode(dig);
      num_q <= blank ? BLANK_NUM : shadow[{dig, 2'b00} +: 4];
      dp_q  <= blank | ~bus.dp_in[dig];
      fd_q  <= wrap;
    end
  assign bus.an         = an_q;
  assign bus.num        = num_q;
  assign bus.dp_n       = dp_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_sseg_scan.sv
// tb_sseg_scan: table, directed and random checks of sseg_scan against a frame-level model
module tb_sseg_scan;
  localparam int D = 4;
  localparam int F = 4 * D;
  logic clk = 1'b0;
  logic reset = 1'b1;
  sseg_scan_if bus();
  sseg_scan #(.CLK_DIV(D)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n;
  logic [15:0] shown, latest;
  bit lv;
  int exp_d;
  logic [15:0] exp_sh;
  logic [3:0] e_an, e_num;
  logic e_dpn, e_fd;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dp;
    logic        lzb;
    int          slot;
    logic [3:0]  an;
    logic [3:0]  num;
    logic        dpn;
  } vec_t;
  vec_t vt[10];

  function automatic logic [9:0] outs();
    return {bus.an, bus.num, bus.dp_n, bus.frame_done};
  endfunction

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @n=%0d: got an=%b num=%h dp_n=%b fd=%b, want an=%b num=%h dp_n=%b fd=%b",
               name, n, act[9:6], act[5:2], act[1], act[0], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic model_reset();
    n = 0;
    shown = '0;
    latest = '0;
    lv = 0;
  endtask

  // edge n shows digit (n/D)%4 of the frame's value; frames switch on edges with n%F==F-1
  task automatic step();
    bit blank;
    exp_d  = (n / D) % 4;
    exp_sh = shown;
    blank  = bus.lzb && exp_d != 0 && (shown >> (4 * exp_d)) == 16'h0;
    e_an   = blank ? 4'hF : ~(4'b0001 << exp_d);
    e_num  = blank ? 4'hF : 4'((shown >> (4 * exp_d)) & 16'hF);
    e_dpn  = blank | ~bus.dp_in[exp_d];
    e_fd   = (n % F) == F - 1;
    if (bus.load) begin
      latest = bus.value;
      lv = 1;
    end
    if (n % F == F - 1 && lv) shown = latest;
    n++;
    @(posedge clk);
    @(negedge clk);
    chk("scan", outs(), {e_an, e_num, e_dpn, e_fd});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    bit found;
    vt[0] = '{16'h1234, 4'b0000, 1'b0, 0, 4'b1110, 4'h4, 1'b1};
    vt[1] = '{16'h1234, 4'b0000, 1'b0, 3, 4'b0111, 4'h1, 1'b1};
    vt[2] = '{16'h0005, 4'b0000, 1'b1, 0, 4'b1110, 4'h5, 1'b1};
    vt[3] = '{16'h0005, 4'b0000, 1'b1, 1, 4'b1111, 4'hF, 1'b1};
    vt[4] = '{16'h0005, 4'b0000, 1'b1, 3, 4'b1111, 4'hF, 1'b1};
    vt[5] = '{16'h0000, 4'b0100, 1'b0, 2, 4'b1011, 4'h0, 1'b0};
    vt[6] = '{16'h0001, 4'b0100, 1'b1, 2, 4'b1111, 4'hF, 1'b1};
    vt[7] = '{16'h0001, 4'b0001, 1'b1, 0, 4'b1110, 4'h1, 1'b0};
    vt[8] = '{16'h0100, 4'b0000, 1'b1, 1, 4'b1101, 4'h0, 1'b1};
    vt[9] = '{16'h0100, 4'b0000, 1'b1, 2, 4'b1011, 4'h1, 1'b1};
    bus.value = '0;
    bus.load  = 1'b0;
    bus.dp_in = '0;
    bus.lzb   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", outs(), {4'b1111, 4'h0, 1'b1, 1'b0});
    reset = 1'b0;
    model_reset();
    repeat (F) step();
    repeat (5) step();
    bus.value = 16'h1234;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    repeat (2 * F) step();
    for (int i = 0; i < 10; i++) begin
      bus.value = vt[i].val;
      bus.load  = 1'b1;
      bus.dp_in = vt[i].dp;
      bus.lzb   = vt[i].lzb;
      step();
      bus.load = 1'b0;
      found = 0;
      for (int k = 0; k < 3 * F && !found; k++) begin
        step();
        if (exp_sh == vt[i].val && exp_d == vt[i].slot) begin
          found = 1;
          chk($sformatf("vec%0d", i), outs(), {vt[i].an, vt[i].num, vt[i].dpn, e_fd});
        end
      end
      if (!found) begin
        tests++;
        fails++;
        $display("FAIL vec%0d: got no matching slot, want slot %0d within %0d cycles", i, vt[i].slot, 3 * F);
      end
    end
    bus.lzb = 1'b0;
    bus.dp_in = '0;
    while (n % F != 2) step();
    bus.value = 16'hAAAA;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    bus.value = 16'hBBBB;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    while (n % F != 0) step();
    step();
    chk("overwrite_bbbb", outs(), {4'b1110, 4'hB, 1'b1, 1'b0});
    while (n % F != F - 1) step();
    bus.value = 16'hCCCC;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    chk("load_on_wrap", outs(), {4'b1110, 4'hC, 1'b1, 1'b0});
    p = 0;
    repeat (3 * F) begin
      step();
      p += int'(bus.frame_done);
    end
    tests++;
    if (p != 3) begin
      fails++;
      $display("FAIL frame_done_count: got %0d pulses, want 3", p);
    end
    repeat (400) begin
      bus.value = 16'($urandom);
      bus.load  = $urandom_range(0, 7) == 0;
      bus.dp_in = 4'($urandom);
      bus.lzb   = 1'($urandom);
      step();
    end
    bus.load = 1'b0;
    bus.lzb = 1'b0;
    bus.dp_in = '0;
    while (n % F != 3) step();
    bus.value = 16'hFFFF;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    repeat (3) step();
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("async_reset", outs(), {4'b1111, 4'h0, 1'b1, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step();
    chk("post_reset_dig0", outs(), {4'b1110, 4'h0, 1'b1, 1'b0});
    repeat (2 * F) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sseg_scan.md
SSEG_SCAN -- requirements
Module: sseg_scan

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, clock cycles per digit slot (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port value  input  16  four hex nibbles; digit i = value[4i+3:4i], digit 0 rightmost.
REQ-005 SHALL have port load  input  1  strobe; captures value when high at a clock edge.
REQ-006 SHALL have port dp_in  input  4  decimal point request per digit, active-high.
REQ-007 SHALL have port lzb  input  1  leading-zero blanking enable.
REQ-008 SHALL have port num  output  4  nibble for the active digit, feeds the existing sseg_driver num input.
REQ-009 SHALL have port an  output  4  digit anode enables, active-low, one-hot-low or all-high.
REQ-010 SHALL have port dp_n  output  1  decimal point, active-low.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at each 3->0 digit wrap.

Function
REQ-012 Prescaler cnt SHALL count 0..CLK_DIV-1 and wrap; tick SHALL be high in the cycle cnt==CLK_DIV-1.
REQ-013 Digit index dig (2 bits) SHALL increment modulo 4 on the edge that consumes tick.
REQ-014 On load, value SHALL be captured into a pending register and the pending flag set; repeated loads overwrite pending.
REQ-015 Displayed shadow register SHALL update from pending only on the edge where dig wraps 3->0, clearing the pending flag; no mid-frame tearing.
REQ-016 If load coincides with the wrap edge, shadow SHALL take the value presented at that edge and pending flag SHALL clear.
REQ-017 frame_done SHALL be registered, high exactly one cycle after the wrap edge.
REQ-018 num, an, dp_n SHALL be registered from dig and shadow: one-cycle latency after dig changes.
REQ-019 For active digit i not blanked: an[i]=0, other an bits 1, num=shadow nibble i, dp_n=~dp_in[i].
REQ-020 With lzb=1, digit i (i=3,2,1) SHALL be blanked when shadow nibbles 3..i are all zero; digit 0 never blanked.
REQ-021 Blanked digit: an=4'b1111, num=4'hF, dp_n=1 (dp suppressed).
REQ-022 lzb and dp_in SHALL be sampled live each cycle (not shadowed).

Reset
REQ-023 reset high SHALL asynchronously force cnt=0, dig=0, shadow=0, pending=0, pending flag=0.
REQ-024 reset SHALL force outputs an=4'b1111, num=0, dp_n=1, frame_done=0.
REQ-025 reset asserted mid-frame SHALL discard pending data; after release, first output cycle shows digit 0.

Structure
REQ-026 Shared package/header SHALL hold NUM_DIGITS=4, AN_OFF=4'b1111, BLANK_NUM=4'hF.
REQ-027 Prescaler SHALL be a sub-module sseg_tick (parameter CLK_DIV, ports clk, reset, tick).
REQ-028 sseg_driver SHALL not be instantiated inside; integration top connects num to it.

Verification (CLK_DIV=4)
REQ-029 Reset release, no load -> an sequence 1110,1101,1011,0111 each 4 cycles, num=0 throughout.
REQ-030 load value=16'h1234 at cycle 5 -> display unchanged until first wrap; next frame num=4,3,2,1 with an 1110..0111; frame_done pulses every 16 cycles.
REQ-031 lzb=1, value=16'h0005 -> only digit 0 enabled (an=1110, num=5); other slots an=1111, num=F.
REQ-032 Loads 16'hAAAA then 16'hBBBB within one frame -> next frame shows BBBB only; load of 16'hCCCC on wrap edge -> CCCC shown that frame.
REQ-033 dp_in=4'b0100 -> dp_n=0 only while an=1011; with lzb=1 and value=16'h0001, dp_n stays 1 in blanked slot 2.
REQ-034 reset pulse mid-frame with pending 16'hFFFF -> outputs reset immediately; after release digits show 0.
